// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: serial-to-parallel word receiver with valid/ready output and sticky overrun; define SIPO_PARITY_CHECK_EN for a trailing parity bit
module sipo_frame_receiver #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       shift_left,
    input  logic                       shift_right,
    input  logic                       data_in,
    input  logic                       out_ready,
    input  logic                       ovr_clr,
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_valid,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun,
    output logic                       parity_err
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_CHECK_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    logic [WIDTH-1:0] asm_q, asm_nxt, word;
    logic accept, done, load, perr;
    always_comb begin
        accept  = shift_left ^ shift_right;
        asm_nxt = shift_left ? {asm_q[WIDTH-2:0], data_in} : {data_in, asm_q[WIDTH-1:1]};
        done    = accept && bit_count == CW'(FL - 1);
        load    = done && (!out_valid || out_ready);
    end
`ifdef SIPO_PARITY_CHECK_EN
    assign word = asm_q;
    assign perr = ^asm_q ^ data_in ^ PARITY_ODD;
`else
    assign word = asm_nxt;
    assign perr = 1'b0 & PARITY_ODD;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q      <= '0;
            bit_count  <= '0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (accept) begin
                asm_q     <= asm_nxt;
                bit_count <= done ? '0 : bit_count + CW'(1);
            end
            if (load) begin
                data_out   <= word;
                out_valid  <= 1'b1;
                parity_err <= perr;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            overrun <= (done && out_valid && !out_ready) || (overrun && !ovr_clr);
        end
    end
endmodule

// File: tb/tb_sipo_frame_receiver.sv
// tb_sipo_frame_receiver: directed and randomized checks of sipo_frame_receiver against a word-level reference model
module tb_sipo_frame_receiver;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
`ifdef SIPO_PARITY_CHECK_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    logic clk = 0, reset = 1, sl = 0, sr = 0, d = 0, rdy = 0, clr = 0;
    logic [W-1:0]  data_out;
    logic          out_valid, overrun, parity_err;
    logic [CW-1:0] bit_count;
    int n_vec = 0, n_err = 0;
    int m_asm = 0, m_cnt = 0, m_dout = 0, m_valid = 0, m_ovr = 0, m_perr = 0;

    sipo_frame_receiver #(.WIDTH(W), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .reset(reset), .shift_left(sl), .shift_right(sr), .data_in(d),
        .out_ready(rdy), .ovr_clr(clr), .data_out(data_out), .out_valid(out_valid),
        .bit_count(bit_count), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: applies one clock edge worth of the receiver rules to the model state
    task automatic model_edge();
        int prev, done, was_valid;
        done = 0;
        was_valid = m_valid;
        if (reset) begin
            m_asm = 0; m_cnt = 0; m_dout = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
            return;
        end
        prev = m_asm;
        if (sl != sr) begin
            m_asm = sl ? ((m_asm * 2) + d) % (1 << W) : (m_asm / 2) + (d << (W - 1));
            if (m_cnt == FL - 1) begin
                done = 1;
                m_cnt = 0;
            end else m_cnt++;
        end
        if (done && (!was_valid || rdy)) begin
            m_valid = 1;
`ifdef SIPO_PARITY_CHECK_EN
            m_dout = prev;
            m_perr = (($countones(prev) + d) % 2) != 0;
`else
            m_dout = m_asm;
            m_perr = 0;
`endif
        end else if (was_valid && rdy) m_valid = 0;
        m_ovr = (done && was_valid && !rdy) || (m_ovr && !clr);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("data_out", data_out, m_dout);
        check("out_valid", out_valid, m_valid);
        check("bit_count", bit_count, m_cnt);
        check("overrun", overrun, m_ovr);
        check("parity_err", parity_err, m_perr);
    endtask

    task automatic send_bit(input logic left, input logic b);
        sl = left; sr = !left; d = b;
        step();
        sl = 0; sr = 0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic left);
        for (int i = 0; i < W; i++) send_bit(left, left ? w[W-1-i] : w[i]);
`ifdef SIPO_PARITY_CHECK_EN
        send_bit(left, ^w);
`endif
    endtask

    initial begin
        logic [W-1:0] w;
        reset = 1;
        step();
        check("rst_valid", out_valid, 0);
        check("rst_count", bit_count, 0);
        reset = 0;
        for (int i = 0; i < 3; i++) send_bit(1, 1);
        check("partial_count", bit_count, 3);
        reset = 1;
        step();
        reset = 0;
        check("midframe_rst", bit_count, 0);
        rdy = 0;
        send_word(8'hA5, 1);
        check("msb_first_data", data_out, 8'hA5);
        check("msb_first_valid", out_valid, 1);
        check("msb_first_count", bit_count, 0);
        rdy = 1;
        step();
        check("drain_valid", out_valid, 0);
        send_word(8'h3C, 0);
        check("lsb_first_data", data_out, 8'h3C);
        check("lsb_first_valid", out_valid, 1);
        step();
        check("lsb_one_cycle", out_valid, 0);
        w = 8'h5A;
        for (int i = 0; i < W; i++) begin
            send_bit(1, w[W-1-i]);
            sl = i[0]; sr = i[0];
            step();
            check("idle_hold_count", bit_count, (i + 1) % FL);
            sl = 0; sr = 0;
        end
`ifdef SIPO_PARITY_CHECK_EN
        send_bit(1, ^w);
`endif
        check("idle_data", data_out, 8'h5A);
        step();
        rdy = 0;
        send_word(8'h11, 1);
        send_word(8'h22, 1);
        check("bp_retained", data_out, 8'h11);
        check("bp_overrun", overrun, 1);
        clr = 1;
        step();
        clr = 0;
        check("ovr_cleared", overrun, 0);
        rdy = 1;
        step();
        check("bp_drop_valid", out_valid, 0);
        rdy = 0;
        send_word(8'h33, 1);
        w = 8'h44;
        for (int i = 0; i < FL - 1; i++) send_bit(1, i < W ? w[W-1-i] : 1'b0);
        rdy = 1;
        send_bit(1, FL > W ? ^w : w[0]);
        check("b2b_data", data_out, 8'h44);
        check("b2b_valid", out_valid, 1);
        check("b2b_overrun", overrun, 0);
        step();
`ifdef SIPO_PARITY_CHECK_EN
        w = 8'h07;
        for (int i = 0; i < W; i++) send_bit(1, w[W-1-i]);
        send_bit(1, 1);
        check("par_ok", parity_err, 0);
        step();
        for (int i = 0; i < W; i++) send_bit(1, w[W-1-i]);
        send_bit(1, 0);
        check("par_bad", parity_err, 1);
        check("par_bad_data", data_out, 8'h07);
        step();
`endif
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 9))
                0: begin sl = 1; sr = 1; end
                1, 2: begin sl = 0; sr = 0; end
                3, 4, 5: begin sl = 1; sr = 0; end
                default: begin sl = 0; sr = 1; end
            endcase
            d = 1'($urandom);
            rdy = ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b1;
            clr = ($urandom_range(0, 15) == 0);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
